// File: rtl/alu_ctrl_pkg.sv
// ALU control shared encodings: funct fields, ALU codes,
// alu_op classes, MDU ops, HI/LO select and decode bundle.
package alu_ctrl_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [3:0] {
    C_AND  = 4'd0,
    C_OR   = 4'd1,
    C_ADD  = 4'd2,
    C_XOR  = 4'd3,
    C_SUB  = 4'd6,
    C_SLT  = 4'd7,
    C_SLTU = 4'd8,
    C_NOR  = 4'd12,
    C_SLL  = 4'd13,
    C_SRL  = 4'd14,
    C_SRA  = 4'd15
  } alu_code_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_RTYPE = 2'd2,
    OP_AND   = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    HL_ALU = 2'd0,
    HL_HI  = 2'd1,
    HL_LO  = 2'd2
  } hilo_e;

  typedef struct packed {
    alu_code_e ctrl;
    logic      jr;
    hilo_e     hilo;
    logic      mdu_req;
    mdu_op_e   mdu_op;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decode into ALU code,
// jr, HI/LO select, MDU request and illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{
      ctrl:    C_ADD,
      jr:      1'b0,
      hilo:    HL_ALU,
      mdu_req: 1'b0,
      mdu_op:  MDU_MULT,
      illegal: 1'b0
    };
    unique case (1'b1)
      (alu_op == OP_ADD): dec.ctrl = C_ADD;
      (alu_op == OP_SUB): dec.ctrl = C_SUB;
      (alu_op == OP_AND): dec.ctrl = C_AND;
      (alu_op == OP_RTYPE): begin
        unique case (funct)
          F_AND:          dec.ctrl = C_AND;
          F_OR:           dec.ctrl = C_OR;
          F_ADD, F_ADDU:  dec.ctrl = C_ADD;
          F_XOR:          dec.ctrl = C_XOR;
          F_SUB, F_SUBU:  dec.ctrl = C_SUB;
          F_SLT:          dec.ctrl = C_SLT;
          F_SLTU:         dec.ctrl = C_SLTU;
          F_NOR:          dec.ctrl = C_NOR;
          F_SLL:          dec.ctrl = C_SLL;
          F_SRL:          dec.ctrl = C_SRL;
          F_SRA:          dec.ctrl = C_SRA;
          F_JR:           dec.jr   = 1'b1;
          F_MFHI:         dec.hilo = HL_HI;
          F_MFLO:         dec.hilo = HL_LO;
          F_MULT, F_MULTU,
          F_DIV, F_DIVU: begin
            dec.mdu_req = 1'b1;
            // low funct bits line up with the MDU op order
            dec.mdu_op  = mdu_op_e'(funct[1:0]);
          end
          default:        dec.illegal = 1'b1;
        endcase
      end
      default: dec.ctrl = C_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control_mc.sv
// Registered EX-stage ALU control with multi-cycle
// mult/div sequencing and pipeline stall.
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              jump_reg,
  output logic [1:0]        hilo_sel,
  output logic              mdu_start,
  output logic [1:0]        mdu_op,
  output logic              stall,
  output logic              valid_out,
  output logic              illegal
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             accept;
  logic             launch;

  alu_ctrl_decode u_dec (
    .alu_op (alu_op),
    .funct  (funct),
    .dec    (dec)
  );

  assign stall  = (state == BUSY);
  assign accept = valid_in & ~stall & ~flush;
  assign launch = accept & dec.mdu_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_ctrl  <= '0;
      jump_reg  <= 1'b0;
      hilo_sel  <= '0;
      mdu_start <= 1'b0;
      mdu_op    <= '0;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      valid_out <= accept;
      alu_ctrl  <= accept ? CTRL_W'(dec.ctrl) : '0;
      jump_reg  <= accept & dec.jr;
      hilo_sel  <= accept ? dec.hilo : HL_ALU;
      illegal   <= accept & dec.illegal;
      mdu_start <= launch;
      mdu_op    <= launch ? dec.mdu_op : MDU_MULT;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state <= BUSY;
            cnt   <= dec.mdu_op[1]
                     ? CNT_W'(DIV_CYCLES - 1)
                     : CNT_W'(MUL_CYCLES - 1);
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed and random checks of alu_control_mc against
// a remaining-busy-cycles reference model.
module tb_alu_control_mc;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic       flush;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [3:0] alu_ctrl;
  logic       jump_reg;
  logic [1:0] hilo_sel;
  logic       mdu_start;
  logic [1:0] mdu_op;
  logic       stall;
  logic       valid_out;
  logic       illegal;

  int nerr = 0;
  int nchk = 0;
  int busy_rem = 0;
  int stall_cnt = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  alu_control_mc #(
    .CTRL_W(4), .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .flush(flush),
    .alu_op(alu_op), .funct(funct),
    .alu_ctrl(alu_ctrl), .jump_reg(jump_reg),
    .hilo_sel(hilo_sel), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .stall(stall),
    .valid_out(valid_out), .illegal(illegal)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    nchk++;
    assert (obs === 32'(exp)) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(
    input int op, input int fn,
    output int c, output int j, output int h,
    output int m, output int mo, output int il);
    c = 2; j = 0; h = 0; m = 0; mo = 0; il = 0;
    if (op == 0) c = 2;
    else if (op == 1) c = 6;
    else if (op == 3) c = 0;
    else begin
      case (fn)
        36: c = 0;
        37: c = 1;
        32, 33: c = 2;
        38: c = 3;
        34, 35: c = 6;
        42: c = 7;
        43: c = 8;
        39: c = 12;
        0: c = 13;
        2: c = 14;
        3: c = 15;
        8: j = 1;
        16: h = 1;
        18: h = 2;
        24, 25, 26, 27: begin
          m = 1;
          mo = fn - 24;
        end
        default: il = 1;
      endcase
    end
  endfunction

  task automatic step(input bit r, input bit v,
                      input bit f, input int op,
                      input int fn);
    int c, j, h, m, mo, il;
    bit pre, acc;
    @(negedge clk);
    reset = r;
    valid_in = v;
    flush = f;
    alu_op = op[1:0];
    funct = fn[5:0];
    #1;
    pre = (busy_rem > 0);
    chk("stall_pre", {31'd0, stall}, int'(pre));
    if (pre) stall_cnt++;
    @(posedge clk);
    #1;
    ref_dec(op, fn, c, j, h, m, mo, il);
    acc = !r && v && !f && !pre;
    if (!acc) begin
      c = 0; j = 0; h = 0; m = 0; mo = 0; il = 0;
      if (r) busy_rem = 0;
      else if (busy_rem > 0) busy_rem--;
    end else if (m == 1) begin
      busy_rem = ((mo >= 2) ? DIV_N : MUL_N) - 1;
    end
    if (mdu_start === 1'b1) start_cnt++;
    chk("valid_out", {31'd0, valid_out}, int'(acc));
    chk("alu_ctrl", {28'd0, alu_ctrl}, c);
    chk("jump_reg", {31'd0, jump_reg}, j);
    chk("hilo_sel", {30'd0, hilo_sel}, h);
    chk("illegal", {31'd0, illegal}, il);
    chk("mdu_start", {31'd0, mdu_start}, m);
    chk("mdu_op", {30'd0, mdu_op}, mo);
    chk("stall_post", {31'd0, stall},
        int'(busy_rem > 0));
  endtask

  int sweep_f[11] = '{36, 37, 32, 38, 34, 42,
                      43, 39, 0, 2, 3};
  int sweep_c[11] = '{0, 1, 2, 3, 6, 7,
                      8, 12, 13, 14, 15};
  int legal[22] = '{0, 2, 3, 8, 16, 18, 24, 25,
                    26, 27, 32, 33, 34, 35, 36,
                    37, 38, 39, 42, 43, 5, 63};

  initial begin
    reset = 1'b1;
    valid_in = 1'b1;
    flush = 1'b0;
    alu_op = 2'd2;
    funct = 6'd24;
    @(posedge clk);

    // reset held with a pending mult
    start_cnt = 0;
    step(1, 1, 0, 2, 24);
    step(1, 1, 0, 2, 24);
    chk("reset_no_start", start_cnt, 0);
    chk("reset_stall", {31'd0, stall}, 0);

    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, 2, sweep_f[i]);
      chk("sweep", {28'd0, alu_ctrl}, sweep_c[i]);
    end

    step(0, 1, 0, 2, 8);
    chk("jr", {31'd0, jump_reg}, 1);
    step(0, 1, 0, 2, 5);
    chk("illegal5", {31'd0, illegal}, 1);
    step(0, 1, 0, 3, 8);
    chk("andi", {28'd0, alu_ctrl}, 0);

    // div followed by a queued mflo
    start_cnt = 0;
    stall_cnt = 0;
    step(0, 1, 0, 2, 26);
    chk("div_op", {30'd0, mdu_op}, 2);
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0, 2, 18);
      if (valid_out === 1'b1) break;
    end
    chk("div_stall_cycles", stall_cnt, 31);
    chk("div_starts", start_cnt, 1);
    chk("mflo_hilo", {30'd0, hilo_sel}, 2);

    // flushed mult never launches
    start_cnt = 0;
    step(0, 1, 1, 2, 24);
    chk("flush_no_start", start_cnt, 0);
    stall_cnt = 0;
    step(0, 1, 0, 2, 24);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 2, 32);
    chk("mul_flush_stall", stall_cnt, 3);
    chk("mul_starts", start_cnt, 1);

    // reset in the middle of a div
    step(0, 1, 0, 2, 27);
    for (int i = 0; i < 21; i++) step(0, 0, 0, 0, 0);
    chk("pre_reset_busy", {31'd0, stall}, 1);
    step(1, 0, 0, 0, 0);
    chk("reset_mid_busy", {31'd0, stall}, 0);
    step(0, 1, 0, 0, 0);
    chk("add_after_reset", {31'd0, valid_out}, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0,
           ($urandom % 4) != 0,
           ($urandom % 8) == 0,
           int'($urandom % 4),
           (($urandom % 6) == 0)
             ? int'($urandom % 64)
             : legal[$urandom % 22]);
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
